// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder for the MEM stage: one word access at a time,
// stalls the pipeline for LATENCY busy cycles, then commits a write or returns read data.
// Ports: clk_i, rst_i (async, active-low), MemRead_i, MemWrite_i, addr_i (byte address),
//        wdata_i -> rdata_o, valid_o (read-done pulse), stall_o, conflict_o (both-ops pulse).
module data_mem_responder #(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        valid_o,
    output logic        stall_o,
    output logic        conflict_o
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                conflict_q, conflict_d;
    logic                mem_we;
    logic                req;

    logic [31:0]         mem_q [2**ADDR_W];

    // Upper address bits alias; byte-offset bits are don't-care.
    logic                unused_addr;
    assign unused_addr = ^{addr_i[31:ADDR_W+2], addr_i[1:0]};

    assign req = MemRead_i | MemWrite_i;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wr_d       = wr_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        conflict_d = 1'b0;
        mem_we     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    state_d    = BUSY;
                    cnt_d      = CNT_INIT;
                    // A simultaneous read+write is resolved as a write.
                    wr_d       = MemWrite_i;
                    idx_d      = addr_i[ADDR_W+1:2];
                    wdata_d    = wdata_i;
                    conflict_d = MemRead_i & MemWrite_i;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    if (wr_q) begin
                        mem_we = 1'b1;
                    end else begin
                        rdata_d = mem_q[idx_q];
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            wr_q       <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= 32'd0;
            rdata_q    <= 32'd0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wr_q       <= wr_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            conflict_q <= conflict_d;
        end
    end

    // Array is never cleared; a reset returns the FSM to IDLE so no write fires.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign rdata_o    = rdata_q;
    assign valid_o    = (state_q == DONE) && !wr_q;
    assign conflict_o = conflict_q;
    assign stall_o    = rst_i &&
                        ((state_q == BUSY) || ((state_q == IDLE) && req));

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed + random
// accesses vs a word model; LATENCY=1 back-to-back.
module tb_data_mem_responder;

  localparam int LAT = 3;

  logic        clk;
  logic        rst_n;
  logic        rd, wr;
  logic [31:0] addr, wdata, rdata;
  logic        valid, stall, conflict;
  logic        rd1, wr1;
  logic [31:0] addr1, wdata1, rdata1;
  logic        valid1, stall1, conflict1;

  int errors = 0;
  int checks = 0;

  logic [31:0] model [256];
  bit          known [256];
  logic [31:0] exp_rdata;
  bit          rdata_known;

  data_mem_responder #(.ADDR_W(8), .LATENCY(LAT)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .MemRead_i(rd), .MemWrite_i(wr),
    .addr_i(addr), .wdata_i(wdata),
    .rdata_o(rdata), .valid_o(valid),
    .stall_o(stall), .conflict_o(conflict)
  );

  data_mem_responder #(.ADDR_W(8), .LATENCY(1)) dut1 (
    .clk_i(clk), .rst_i(rst_n),
    .MemRead_i(rd1), .MemWrite_i(wr1),
    .addr_i(addr1), .wdata_i(wdata1),
    .rdata_o(rdata1), .valid_o(valid1),
    .stall_o(stall1), .conflict_o(conflict1)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic access(input bit is_wr, input bit both,
                        input logic [31:0] a,
                        input logic [31:0] d);
    int n;
    int vbusy;
    bit done;
    bit eff_wr;
    logic [7:0] ix;
    ix = a[9:2];
    eff_wr = is_wr || both;
    @(posedge clk); #1;
    rd = !is_wr || both;
    wr = eff_wr;
    addr = a;
    wdata = d;
    @(negedge clk);
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL stall_first: got %b expected 1", stall);
    end
    @(posedge clk); #1;
    rd = 0;
    wr = 0;
    addr = $urandom;
    wdata = $urandom;
    n = 1;
    vbusy = 0;
    done = 0;
    for (int c = 1; c < 20 && !done; c++) begin
      @(negedge clk);
      checks++;
      if (conflict !== (both && c == 1)) begin
        errors++;
        $display("FAIL conflict c=%0d: got %b expected %b",
                 c, conflict, both && c == 1);
      end
      if (stall === 1'b1) begin
        n++;
        if (valid !== 1'b0) vbusy++;
      end else begin
        done = 1;
      end
    end
    checks++;
    if (!done || n != LAT + 1) begin
      errors++;
      $display("FAIL stall_len: got %0d expected %0d",
               n, LAT + 1);
    end
    checks++;
    if (valid !== !eff_wr || vbusy != 0) begin
      errors++;
      $display("FAIL valid_done: got %b (busy %0d) expected %b",
               valid, vbusy, !eff_wr);
    end
    if (eff_wr) begin
      model[ix] = d;
      known[ix] = 1;
      if (rdata_known) begin
        checks++;
        if (rdata !== exp_rdata) begin
          errors++;
          $display("FAIL rdata_hold: got %h expected %h",
                   rdata, exp_rdata);
        end
      end
    end else if (known[ix]) begin
      checks++;
      if (rdata !== model[ix]) begin
        errors++;
        $display("FAIL rdata idx=%0d: got %h expected %h",
                 ix, rdata, model[ix]);
      end
      exp_rdata = model[ix];
      rdata_known = 1;
    end else begin
      rdata_known = 0;
    end
  endtask

  task automatic test_reset();
    int n;
    bit done;
    rst_n = 0;
    rd = 1;
    wr = 0;
    addr = 0;
    wdata = 0;
    rd1 = 0;
    wr1 = 0;
    addr1 = 0;
    wdata1 = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL rst_stall: got %b expected 0", stall);
    end
    checks++;
    if (rdata !== 32'd0) begin
      errors++;
      $display("FAIL rst_rdata: got %h expected 0", rdata);
    end
    checks++;
    if (valid !== 1'b0 || conflict !== 1'b0) begin
      errors++;
      $display("FAIL rst_valid: got %b%b expected 00",
               valid, conflict);
    end
    checks++;
    if (stall1 !== 1'b0 || rdata1 !== 32'd0) begin
      errors++;
      $display("FAIL rst_dut1: got %b %h expected 0 0",
               stall1, rdata1);
    end
    rst_n = 1;
    @(posedge clk); #1;
    rd = 0;
    @(negedge clk);
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL rst_capture: got %b expected 1", stall);
    end
    n = 1;
    done = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (stall === 1'b1) n++;
      else done = 1;
    end
    checks++;
    if (!done || n != LAT || valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_first_read: got %0d %b expected %0d 1",
               n, valid, LAT);
    end
    rdata_known = 0;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 256; i++) begin
      logic [31:0] a;
      a = $urandom;
      a[9:2] = 8'(i);
      access(1, 0, a, $urandom);
    end
  endtask

  task automatic test_write_read();
    access(1, 0, 32'h10, 32'hDEADBEEF);
    access(0, 0, 32'h10, 32'h0);
    checks++;
    if (rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL wr_rd: got %h expected deadbeef", rdata);
    end
  endtask

  task automatic test_alias();
    access(1, 0, 32'h400, 32'h1);
    access(0, 0, 32'h0, 32'h0);
    checks++;
    if (rdata !== 32'h1) begin
      errors++;
      $display("FAIL alias: got %h expected 00000001", rdata);
    end
  endtask

  task automatic test_conflict();
    access(0, 1, 32'h8, 32'h55);
    access(0, 0, 32'h8, 32'h0);
    checks++;
    if (rdata !== 32'h55) begin
      errors++;
      $display("FAIL conflict_data: got %h expected 00000055",
               rdata);
    end
  endtask

  task automatic test_reset_mid_busy();
    access(1, 0, 32'h4, 32'h0);
    @(posedge clk); #1;
    wr = 1;
    addr = 32'h4;
    wdata = 32'hAA;
    @(posedge clk); #1;
    wr = 0;
    @(negedge clk);
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL midrst_busy: got %b expected 1", stall);
    end
    rst_n = 0;
    #1;
    checks++;
    if (stall !== 1'b0 || rdata !== 32'd0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_clear: got %b %h %b expected 0 0 0",
               stall, rdata, valid);
    end
    exp_rdata = 0;
    rdata_known = 1;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL midrst_idle: got %b expected 0", stall);
    end
    access(0, 0, 32'h4, 32'h0);
    checks++;
    if (rdata !== 32'h0) begin
      errors++;
      $display("FAIL midrst_data: got %h expected 0", rdata);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      int k;
      k = $urandom_range(0, 3);
      access(k == 2, k == 3, $urandom, $urandom);
    end
  endtask

  task automatic test_back_to_back();
    bit pat [6];
    bit done;
    logic [31:0] d;
    pat = '{1, 1, 0, 1, 1, 0};
    d = $urandom;
    @(posedge clk); #1;
    wr1 = 1;
    addr1 = 32'h20;
    wdata1 = d;
    @(posedge clk); #1;
    wr1 = 0;
    done = 0;
    for (int c = 0; c < 10 && !done; c++) begin
      @(negedge clk);
      if (stall1 === 1'b0) done = 1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL b2b_write: got stuck expected done");
    end
    @(posedge clk); #1;
    rd1 = 1;
    addr1 = 32'h20;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (stall1 !== pat[c] || valid1 !== !pat[c]) begin
        errors++;
        $display("FAIL b2b c=%0d: got %b %b expected %b %b",
                 c, stall1, valid1, pat[c], !pat[c]);
      end
      if (!pat[c]) begin
        checks++;
        if (rdata1 !== d) begin
          errors++;
          $display("FAIL b2b_data c=%0d: got %h expected %h",
                   c, rdata1, d);
        end
      end
    end
    @(posedge clk); #1;
    rd1 = 0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) known[i] = 0;
    exp_rdata = 0;
    rdata_known = 1;
    test_reset();
    test_fill();
    test_write_read();
    test_alias();
    test_conflict();
    test_reset_mid_busy();
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
